// File: rtl/bus_transfer_sequencer_if.sv
// Bus transfer sequencer interface: request handshake, MDR ready and bus/load controls.
interface bus_transfer_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_src;
    logic [4:0]    req_dst;
    logic          mdr_rdy;
    logic [4:0]    bus_sel;
    logic          bus_drive;
    logic [31:0]   dst_load;
    logic [CW-1:0] count;
    logic          busy;
    logic          err;

    // Control-unit side: issues requests and reports memory readiness.
    modport master (
        output req_valid, req_src, req_dst, mdr_rdy,
        input  req_ready, bus_sel, bus_drive, dst_load, count, busy, err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_src, req_dst, mdr_rdy,
        output req_ready, bus_sel, bus_drive, dst_load, count, busy, err
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Queues register-to-register bus transfers and issues one per cycle onto the shared bus,
// holding MDR-sourced transfers until memory read data is ready.
module bus_transfer_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned MDR_SRC = 21
) (
    input  logic                          clk,
    input  logic                          clr,
    bus_transfer_sequencer_if.slave       bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
    } xfer_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_MDR = 2'd2
    } state_e;

    state_e        state_q;
    xfer_t         mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ready_q;
    logic          busy_q;
    logic          err_q;
    logic [4:0]    bus_sel_q;
    logic          bus_drive_q;
    logic [31:0]   dst_load_q;

    logic  fire;
    logic  legal;
    logic  push;
    logic  illegal;
    logic  pop;
    logic  nxt_avail;
    logic  nxt_wait;
    xfer_t in_req;
    xfer_t nxt_head;

    // Handshake decode and selection of the entry that will be at the head after this edge.
    always_comb begin
        fire     = bus.req_valid && ready_q;
        legal    = 32'(bus.req_src) < NUM_SRC;
        push     = fire && legal;
        illegal  = fire && !legal;
        pop      = (state_q == XFER);
        count_d  = count_q + CW'(push) - CW'(pop);
        in_req   = '{src: bus.req_src, dst: bus.req_dst};
        nxt_avail = 1'b0;
        nxt_head  = mem_q[rd_ptr_q];
        if (pop) begin
            // The entry behind the head may be the one arriving this very cycle.
            nxt_avail = (count_q > CW'(1)) || push;
            nxt_head  = (count_q > CW'(1)) ? mem_q[rd_ptr_q + PW'(1)] : in_req;
        end else begin
            nxt_avail = (count_q != '0);
        end
        nxt_wait = (nxt_head.src == 5'(MDR_SRC)) && !bus.mdr_rdy;
    end

    // FIFO storage; pointers and occupancy carry the flush on reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_req;
        end
    end

    // Sequencer FSM, FIFO pointers and registered bus controls.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_sel_q   <= '0;
            bus_drive_q <= 1'b0;
            dst_load_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (illegal) begin
                err_q <= 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
            busy_q  <= (count_d != '0);
            if (nxt_avail && !nxt_wait) begin
                state_q     <= XFER;
                bus_sel_q   <= nxt_head.src;
                bus_drive_q <= 1'b1;
                dst_load_q  <= 32'(1) << nxt_head.dst;
            end else begin
                state_q     <= nxt_avail ? WAIT_MDR : IDLE;
                bus_sel_q   <= '0;
                bus_drive_q <= 1'b0;
                dst_load_q  <= '0;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_drive = bus_drive_q;
    assign bus.dst_load  = dst_load_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer against a queue-based transfer model.
module tb_bus_transfer_sequencer;
    localparam int DEPTH   = 4;
    localparam int NUM_SRC = 24;
    localparam int MDR_SRC = 21;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bus_transfer_sequencer_if #(.DEPTH(DEPTH)) bif ();

    bus_transfer_sequencer #(
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC),
        .MDR_SRC (MDR_SRC)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
    );

    typedef struct {
        int src;
        int dst;
    } ent_t;

    ent_t q[$];
    bit   m_cur;
    bit   m_err;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cur = 1'b0;
        m_err = 1'b0;
    endtask

    // One clock edge of the reference: FIFO order, MDR hold, sticky error.
    task automatic model_edge(input bit v, input int src, input int dst, input bit mdr);
        int  pre;
        bit  rdy;
        bit  avail;
        ent_t e;
        pre = q.size();
        rdy = (pre != DEPTH);
        if (v && rdy && src >= NUM_SRC) m_err = 1'b1;
        if (m_cur) void'(q.pop_front());
        if (v && rdy && src < NUM_SRC) begin
            e.src = src;
            e.dst = dst;
            q.push_back(e);
        end
        avail = m_cur ? (q.size() > 0) : (pre > 0);
        m_cur = avail && !(q[0].src == MDR_SRC && !mdr);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_sel;
        logic [31:0] e_load;
        e_sel  = m_cur ? 32'(q[0].src) : 32'd0;
        e_load = m_cur ? (32'd1 << q[0].dst) : 32'd0;
        check({tag, ".bus_sel"},   32'(bif.bus_sel),   e_sel);
        check({tag, ".bus_drive"}, 32'(bif.bus_drive), 32'(m_cur));
        check({tag, ".dst_load"},  bif.dst_load,       e_load);
        check({tag, ".count"},     32'(bif.count),     32'(q.size()));
        check({tag, ".req_ready"}, 32'(bif.req_ready), 32'(q.size() != DEPTH));
        check({tag, ".busy"},      32'(bif.busy),      32'(q.size() != 0 || m_cur));
        check({tag, ".err"},       32'(bif.err),       32'(m_err));
    endtask

    task automatic cycle(input string tag, input bit v, input int src, input int dst, input bit mdr);
        bif.req_valid = v;
        bif.req_src   = 5'(src);
        bif.req_dst   = 5'(dst);
        bif.mdr_rdy   = mdr;
        @(posedge clk);
        model_edge(v, src, dst, mdr);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_src   = '0;
        bif.req_dst   = '0;
        bif.mdr_rdy   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        clr = 1'b1;

        // Single transfer with fixed latency.
        cycle("single", 1'b1, 3, 7, 1'b0);
        repeat (3) cycle("single", 1'b0, 0, 0, 1'b0);

        // MDR stall then release.
        cycle("mdr", 1'b1, MDR_SRC, 5, 1'b0);
        repeat (3) cycle("mdr", 1'b0, 0, 0, 1'b0);
        cycle("mdr", 1'b0, 0, 0, 1'b1);
        repeat (2) cycle("mdr", 1'b0, 0, 0, 1'b0);

        // Fill to full behind an MDR wait, try a push while full, then drain.
        cycle("burst", 1'b1, MDR_SRC, 1, 1'b0);
        cycle("burst", 1'b1, 2, 2, 1'b0);
        cycle("burst", 1'b1, 4, 3, 1'b0);
        cycle("burst", 1'b1, 5, 4, 1'b0);
        cycle("burst", 1'b1, 6, 9, 1'b0);
        cycle("burst", 1'b0, 0, 0, 1'b1);
        repeat (5) cycle("burst", 1'b0, 0, 0, 1'b0);

        // Illegal source is dropped, error sticks.
        cycle("illegal", 1'b1, 24, 2, 1'b0);
        cycle("illegal", 1'b1, 0, 2, 1'b0);
        repeat (3) cycle("illegal", 1'b0, 0, 0, 1'b0);

        // Streaming at constant occupancy with a push every cycle.
        cycle("stream", 1'b1, MDR_SRC, 10, 1'b0);
        cycle("stream", 1'b1, 11, 11, 1'b0);
        for (int i = 0; i < 10; i++) cycle("stream", 1'b1, i, 31 - i, 1'b1);
        repeat (4) cycle("stream", 1'b0, 0, 0, 1'b0);

        // Random traffic, including occasional illegal sources.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 9) < 6), int'($urandom_range(0, 26)),
                  int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        repeat (6) cycle("rand_drain", 1'b0, 0, 0, 1'b1);

        // Asynchronous reset in the middle of a transfer.
        cycle("abort", 1'b1, 3, 7, 1'b0);
        bif.req_valid = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 0, 0, 1'b0);
        #1;
        check("abort.in_xfer", 32'(bif.bus_drive), 32'(m_cur));
        #1;
        clr = 1'b0;
        #1;
        model_reset();
        check("abort.dst_load",  bif.dst_load,       32'd0);
        check("abort.bus_drive", 32'(bif.bus_drive), 32'd0);
        check("abort.count",     32'(bif.count),     32'd0);
        check("abort.req_ready", 32'(bif.req_ready), 32'd1);
        check("abort.err",       32'(bif.err),       32'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) cycle("after_abort", 1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
